// File: rtl/rv32v_lane_lsu_if.sv
// Request/response and data-memory bus for the vector lane load/store unit.
// The slave modport is the LSU; master is the requester plus memory side.
interface rv32v_lane_lsu_if #(
   parameter int LANES = 2,
   parameter int AW    = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_load;
   logic                  req_store;
   logic [LANES*AW-1:0]   req_addr;
   logic [LANES*32-1:0]   req_wdata;
   logic [1:0]            req_eew;
   logic                  req_sext;
   logic [LANES-1:0]      req_mask;
   logic [AW-1:0]         dmemaddr;
   logic [31:0]           dmemstore;
   logic                  ren;
   logic                  wen;
   logic [3:0]            byte_ena;
   logic                  dhit;
   logic [31:0]           dmemload;
   logic                  flush;
   logic                  rsp_valid;
   logic [LANES*32-1:0]   rsp_data;
   logic                  rsp_exc;
   logic                  busy;

   modport slave (
      input  req_valid, req_load, req_store, req_addr, req_wdata, req_eew, req_sext, req_mask,
      input  dhit, dmemload, flush,
      output req_ready, dmemaddr, dmemstore, ren, wen, byte_ena,
      output rsp_valid, rsp_data, rsp_exc, busy
   );

   modport master (
      output req_valid, req_load, req_store, req_addr, req_wdata, req_eew, req_sext, req_mask,
      output dhit, dmemload, flush,
      input  req_ready, dmemaddr, dmemstore, ren, wen, byte_ena,
      input  rsp_valid, rsp_data, rsp_exc, busy
   );
endinterface

// File: rtl/rv32v_lane_lsu.sv
// Vector lane load/store unit: walks the active lanes of one request through
// a single 32-bit data port, one word access per active lane.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | word access for lane_q, held until dhit
// DONE   | one-cycle response pulse
module rv32v_lane_lsu #(
   parameter int LANES = 2,
   parameter int AW    = 32
) (
   input  logic                CLK,
   input  logic                nRST,
   rv32v_lane_lsu_if.slave     bus
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic [AW-1:0]    addr_q  [LANES];
   logic [31:0]      wdata_q [LANES];
   logic [31:0]      buf_q   [LANES];
   logic [1:0]       eew_q;
   logic             sext_q, load_q, store_q, exc_q;
   logic [LANES-1:0] mask_q;

   logic             accept, capture;
   logic             req_exc, req_any;
   logic [LW-1:0]    first_lane, next_lane;
   logic             has_next;
   logic [AW-1:0]    cur_addr;
   logic [31:0]      cur_wdata;
   logic [1:0]       off;
   logic [31:0]      load_shift, load_elem;
   logic [3:0]       lane_be;
   logic             ren_c, wen_c, rsp_valid_c, rsp_exc_c;
   logic [3:0]       be_c;

   // Request screening: reserved eew faults regardless of mask.
   always_comb begin
      req_exc    = (bus.req_eew == 2'd3);
      req_any    = |bus.req_mask;
      first_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (bus.req_mask[i]) begin
            first_lane = LW'(i);
            if ((bus.req_eew == 2'd1 && bus.req_addr[i*AW]) ||
                (bus.req_eew == 2'd2 && bus.req_addr[i*AW +: 2] != 2'b00))
               req_exc = 1'b1;
         end
      end
   end

   always_comb begin
      has_next  = 1'b0;
      next_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask_q[i] && (LW'(i) > lane_q)) begin
            has_next  = 1'b1;
            next_lane = LW'(i);
         end
      end
   end

   assign cur_addr   = addr_q[lane_q];
   assign cur_wdata  = wdata_q[lane_q];
   assign off        = cur_addr[1:0];
   assign load_shift = bus.dmemload >> {off, 3'b000};

   always_comb begin
      case (eew_q)
         2'd0:    load_elem = {{24{sext_q & load_shift[7]}},  load_shift[7:0]};
         2'd1:    load_elem = {{16{sext_q & load_shift[15]}}, load_shift[15:0]};
         default: load_elem = load_shift;
      endcase
   end

   always_comb begin
      case (eew_q)
         2'd0:    lane_be = 4'b0001 << off;
         2'd1:    lane_be = 4'b0011 << off;
         default: lane_be = 4'b1111;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      accept      = 1'b0;
      capture     = 1'b0;
      ren_c       = 1'b0;
      wen_c       = 1'b0;
      be_c        = 4'b0000;
      rsp_valid_c = 1'b0;
      rsp_exc_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && !bus.flush) begin
               accept = 1'b1;
               lane_d = first_lane;
               if (req_exc || !req_any) state_d = DONE;
               else                     state_d = ACCESS;
            end
         end
         ACCESS: begin
            ren_c = load_q;
            wen_c = store_q;
            be_c  = lane_be;
            if (bus.dhit) begin
               capture = load_q;
               if (has_next) lane_d  = next_lane;
               else          state_d = DONE;
            end
         end
         DONE: begin
            rsp_valid_c = 1'b1;
            rsp_exc_c   = exc_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Flush beats everything, including a dhit landing in the same cycle.
      if (bus.flush) begin
         state_d = IDLE;
         capture = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < LANES; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            buf_q[i]   <= '0;
         end
         eew_q   <= '0;
         sext_q  <= 1'b0;
         load_q  <= 1'b0;
         store_q <= 1'b0;
         exc_q   <= 1'b0;
         mask_q  <= '0;
      end else if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            addr_q[i]  <= bus.req_addr[i*AW +: AW];
            wdata_q[i] <= bus.req_wdata[i*32 +: 32];
            buf_q[i]   <= '0;
         end
         eew_q   <= bus.req_eew;
         sext_q  <= bus.req_sext;
         load_q  <= bus.req_load;
         store_q <= bus.req_store & ~bus.req_load;
         exc_q   <= req_exc;
         mask_q  <= bus.req_mask;
      end else if (capture) begin
         buf_q[lane_q] <= load_elem;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_rsp
      assign bus.rsp_data[g*32 +: 32] = buf_q[g];
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.dmemaddr  = {cur_addr[AW-1:2], 2'b00};
   assign bus.dmemstore = cur_wdata << {off, 3'b000};
   assign bus.ren       = ren_c;
   assign bus.wen       = wen_c;
   assign bus.byte_ena  = be_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_exc   = rsp_exc_c;
endmodule
